// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer and its watchdog:
//   fsm_state_t          - sequencer state encoding
//   DEFAULT_RESET_VECTOR - default PC loaded on reset
//   TMO_W                - width of the fetch-acknowledge timeout counter
//   is_word_aligned()    - true when an address has its two LSBs clear
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_HALT   = 3'd4
   } fsm_state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   localparam int TMO_W = 8;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// Counts FETCH cycles that pass without an instruction-memory acknowledge.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - zero the counter (asserted on the edge that enters FETCH)
//   enable      - count this cycle (FETCH cycle without ack)
//   limit       - number of unacknowledged cycles allowed
//   expired     - the current cycle is the limit-th one without ack
// -----------------------------------------------------------------------------
module fetch_watchdog
   import fetch_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [TMO_W-1:0] limit,
   output logic             expired
);

   logic [TMO_W-1:0] count_q;

   // count_q holds the number of completed unacknowledged cycles, so the
   // limit-th cycle is the one that starts with count_q == limit-1.
   assign expired = (count_q == (limit - TMO_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + TMO_W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch / execute / PC-update sequencer.
// Parameters:
//   RESET_VECTOR - word-aligned PC loaded on reset
//   ACK_TIMEOUT  - FETCH cycles without imem_ack before a bus error (2..255)
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   run, halt_req       - start / stop requests
//   imem_req, imem_addr - fetch request and address (address is pc)
//   imem_ack, imem_rdata- fetch completion and instruction word
//   instr, instr_valid  - instruction register and execute strobe
//   exec_done           - datapath finished the current instruction
//   pc, pc_next         - current PC and branch-unit next PC
//   retired_count       - instructions retired (wraps modulo 2^32)
//   halted              - sequencer parked in HALT
//   bus_err             - sticky fetch timeout flag
//   misalign_err        - sticky misaligned pc_next flag
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          ACK_TIMEOUT  = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        halt_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        exec_done,
   output logic [31:0] pc,
   input  logic [31:0] pc_next,
   output logic [31:0] retired_count,
   output logic        halted,
   output logic        bus_err,
   output logic        misalign_err
);

   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

   fsm_state_t  state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] retired_q;
   logic        bus_err_q;
   logic        misalign_q;

   logic        wd_clear;
   logic        wd_enable;
   logic        wd_expired;

   logic        fetch_hit;
   logic        fetch_timeout;
   logic        update_ok;
   logic        update_bad;

   fetch_watchdog u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .limit   (TMO_LIMIT),
      .expired (wd_expired)
   );

   // Next-state and event decode. An ack in the timeout cycle still wins.
   always_comb begin
      state_d       = state_q;
      fetch_hit     = 1'b0;
      fetch_timeout = 1'b0;
      update_ok     = 1'b0;
      update_bad    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (run) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               fetch_hit = 1'b1;
               state_d   = ST_EXEC;
            end else if (wd_expired) begin
               fetch_timeout = 1'b1;
               state_d       = ST_HALT;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            if (!is_word_aligned(pc_next)) begin
               update_bad = 1'b1;
               state_d    = ST_HALT;
            end else begin
               update_ok = 1'b1;
               state_d   = halt_req ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The watchdog restarts on every entry into FETCH and counts only
   // unacknowledged FETCH cycles.
   assign wd_clear  = (state_q != ST_FETCH) && (state_d == ST_FETCH);
   assign wd_enable = (state_q == ST_FETCH) && !imem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         retired_q  <= '0;
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         if (fetch_hit) begin
            instr_q <= imem_rdata;
         end
         if (fetch_timeout) begin
            bus_err_q <= 1'b1;
         end
         if (update_ok) begin
            pc_q      <= pc_next;
            retired_q <= retired_q + 32'd1;
         end
         if (update_bad) begin
            misalign_q <= 1'b1;
         end
      end
   end

   // Moore outputs decoded from the state register only.
   assign imem_req      = (state_q == ST_FETCH);
   assign instr_valid   = (state_q == ST_EXEC);
   assign halted        = (state_q == ST_HALT);

   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign instr         = instr_q;
   assign retired_count = retired_q;
   assign bus_err       = bus_err_q;
   assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed self-checking bench for fetch_sequencer: a per-cycle vector table
// for the normal fetch/execute/update flow, then hand-written sequences for
// timeout, misalignment, counter wrap, reset during EXEC and halt requests.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        halt_req;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        exec_done;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] retired_count;
   logic        halted;
   logic        bus_err;
   logic        misalign_err;

   int errors = 0;
   int checks = 0;

   fetch_sequencer #(
      .RESET_VECTOR (RV),
      .ACK_TIMEOUT  (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .halt_req      (halt_req),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .exec_done     (exec_done),
      .pc            (pc),
      .pc_next       (pc_next),
      .retired_count (retired_count),
      .halted        (halted),
      .bus_err       (bus_err),
      .misalign_err  (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic        halt_req;
      logic        ack;
      logic [31:0] rdata;
      logic        done;
      logic [31:0] pcn;
      logic        e_req;
      logic [31:0] e_instr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_ret;
      logic        e_halted;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      run        = 1'b0;
      halt_req   = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      exec_done  = 1'b0;
      pc_next    = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      chk("rst_pc",       pc,            RV);
      chk("rst_instr",    instr,         32'h0);
      chk("rst_retired",  retired_count, 32'h0);
      chk("rst_req",      {31'h0, imem_req},     32'h0);
      chk("rst_valid",    {31'h0, instr_valid},  32'h0);
      chk("rst_halted",   {31'h0, halted},       32'h0);
      chk("rst_bus_err",  {31'h0, bus_err},      32'h0);
      chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();

      //          run  halt ack  rdata          done pc_next    | req instr          vld pc          ret   halted
      vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b0,32'h0,        1'b0,32'h0,     32'd0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,32'h0,        1'b0,32'h0,     32'd0,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b1,32'h13,       1'b0,32'h0,       1'b0,32'h13,       1'b1,32'h0,     32'd0,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h4,       1'b0,32'h13,       1'b0,32'h0,     32'd0,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h4,       1'b1,32'h13,       1'b0,32'h4,     32'd1,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,       1'b1,32'h13,       1'b0,32'h4,     32'd1,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b1,32'hAABBCCDD, 1'b0,32'h0,       1'b0,32'hAABBCCDD, 1'b1,32'h4,     32'd1,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b1,32'h11111111, 1'b0,32'h0,       1'b0,32'hAABBCCDD, 1'b1,32'h4,     32'd1,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,     1'b0,32'hAABBCCDD, 1'b0,32'h4,     32'd1,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,     1'b1,32'hAABBCCDD, 1'b0,32'h100,   32'd2,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b1,32'h13,       1'b1,32'h0,       1'b0,32'h13,       1'b1,32'h100,   32'd2,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h200,     1'b0,32'h13,       1'b0,32'h100,   32'd2,1'b0};
      vecs[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h200,     1'b1,32'h13,       1'b0,32'h200,   32'd3,1'b0};

      // Normal flow, one vector per clock.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         run        = vecs[i].run;
         halt_req   = vecs[i].halt_req;
         imem_ack   = vecs[i].ack;
         imem_rdata = vecs[i].rdata;
         exec_done  = vecs[i].done;
         pc_next    = vecs[i].pcn;
         step();
         chk($sformatf("v%0d_req", i),     {31'h0, imem_req},    {31'h0, vecs[i].e_req});
         chk($sformatf("v%0d_addr", i),    imem_addr,            vecs[i].e_pc);
         chk($sformatf("v%0d_instr", i),   instr,                vecs[i].e_instr);
         chk($sformatf("v%0d_valid", i),   {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
         chk($sformatf("v%0d_pc", i),      pc,                   vecs[i].e_pc);
         chk($sformatf("v%0d_retired", i), retired_count,        vecs[i].e_ret);
         chk($sformatf("v%0d_halted", i),  {31'h0, halted},      {31'h0, vecs[i].e_halted});
         chk($sformatf("v%0d_buserr", i),  {31'h0, bus_err},     32'h0);
         chk($sformatf("v%0d_misalign", i),{31'h0, misalign_err},32'h0);
      end

      // Fetch timeout: 16 FETCH cycles without ack.
      do_reset();
      run = 1'b1;
      step();
      run = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("tmo_c16_halted", {31'h0, halted},   32'h0);
      chk("tmo_c16_req",    {31'h0, imem_req}, 32'h1);
      step();
      chk("tmo_halted",  {31'h0, halted},   32'h1);
      chk("tmo_bus_err", {31'h0, bus_err},  32'h1);
      chk("tmo_req",     {31'h0, imem_req}, 32'h0);
      run = 1'b1;
      step();
      step();
      chk("tmo_sticky_halt", {31'h0, halted},   32'h1);
      chk("tmo_sticky_req",  {31'h0, imem_req}, 32'h0);

      // Ack arriving in the 16th cycle wins; the next fetch gets a fresh budget.
      do_reset();
      run = 1'b1;
      step();
      run = 1'b0;
      for (int i = 0; i < 15; i++) step();
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_0013;
      step();
      imem_ack = 1'b0;
      chk("ack16_valid",   {31'h0, instr_valid}, 32'h1);
      chk("ack16_instr",   instr,                32'hCAFE_0013);
      chk("ack16_bus_err", {31'h0, bus_err},     32'h0);
      chk("ack16_halted",  {31'h0, halted},      32'h0);
      exec_done = 1'b1;
      pc_next   = 32'h4;
      step();
      exec_done = 1'b0;
      step();
      chk("refetch_addr", imem_addr, 32'h4);
      for (int i = 0; i < 15; i++) step();
      chk("refetch_c16_halted", {31'h0, halted}, 32'h0);
      step();
      chk("refetch_tmo_halted", {31'h0, halted},  32'h1);
      chk("refetch_tmo_bus",    {31'h0, bus_err}, 32'h1);

      // Misaligned pc_next in UPDATE.
      do_reset();
      run       = 1'b1;
      imem_ack  = 1'b1;
      exec_done = 1'b1;
      pc_next   = 32'h0000_0102;
      step();
      run = 1'b0;
      step();
      step();
      step();
      chk("mis_err",     {31'h0, misalign_err}, 32'h1);
      chk("mis_halted",  {31'h0, halted},       32'h1);
      chk("mis_pc",      pc,                    RV);
      chk("mis_retired", retired_count,         32'h0);
      chk("mis_bus_err", {31'h0, bus_err},      32'h0);

      // retired_count wrap from 32'hFFFF_FFFF to 0.
      do_reset();
      run        = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h13;
      exec_done  = 1'b1;
      pc_next    = 32'h4;
      step();
      run = 1'b0;
      step();
      step();
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      step();
      chk("wrap_retired", retired_count, 32'h0);
      chk("wrap_pc",      pc,            32'h4);

      // Reset asserted mid-EXEC with pc=32'h40 acts immediately.
      do_reset();
      run        = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h13;
      exec_done  = 1'b1;
      pc_next    = 32'h40;
      step();
      run = 1'b0;
      step();
      step();
      step();
      exec_done  = 1'b0;
      imem_rdata = 32'h5555_0013;
      step();
      imem_ack = 1'b0;
      step();
      chk("pre_rst_valid", {31'h0, instr_valid}, 32'h1);
      chk("pre_rst_pc",    pc,                   32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc",      pc,                   RV);
      chk("async_rst_valid",   {31'h0, instr_valid}, 32'h0);
      chk("async_rst_instr",   instr,                32'h0);
      chk("async_rst_retired", retired_count,        32'h0);
      chk("async_rst_req",     {31'h0, imem_req},    32'h0);
      chk("async_rst_halted",  {31'h0, halted},      32'h0);
      step();
      rst_n = 1'b1;
      idle_inputs();
      step();
      chk("post_rst_idle_req", {31'h0, imem_req}, 32'h0);
      run = 1'b1;
      step();
      chk("post_rst_req",  {31'h0, imem_req}, 32'h1);
      chk("post_rst_addr", imem_addr,         RV);

      // halt_req in UPDATE: update completes, then HALT with no more fetches.
      do_reset();
      run       = 1'b1;
      imem_ack  = 1'b1;
      exec_done = 1'b1;
      pc_next   = 32'h8;
      step();
      run = 1'b0;
      step();
      step();
      halt_req = 1'b1;
      step();
      chk("hup_pc",      pc,               32'h8);
      chk("hup_retired", retired_count,    32'd1);
      chk("hup_halted",  {31'h0, halted},  32'h1);
      halt_req = 1'b0;
      run      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hup_noreq%0d", i), {31'h0, imem_req}, 32'h0);
      end

      // halt_req beats run in IDLE.
      do_reset();
      run      = 1'b1;
      halt_req = 1'b1;
      step();
      chk("idle_halt_halted", {31'h0, halted},   32'h1);
      chk("idle_halt_req",    {31'h0, imem_req}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
